// File: rtl/ram4p_req_scheduler_pkg.sv
// Shared constants and the request record for the 4-port RAM request scheduler.
package ram4p_pkg;

  localparam int NUM_PORTS = 4;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 8;

  localparam logic [1:0] PORT_A = 2'd0;
  localparam logic [1:0] PORT_B = 2'd1;
  localparam logic [1:0] PORT_C = 2'd2;
  localparam logic [1:0] PORT_D = 2'd3;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ram4p_req_scheduler_req_fifo.sv
// Show-ahead synchronous FIFO: dout presents the oldest entry whenever !empty.
module req_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/ram4p_req_scheduler.sv
// Per-port request FIFOs feeding a 4-port RAM; same-address writes are serialised in
// rotating priority order so the RAM never sees two same-cycle writes to one address.
module ram4p_req_scheduler
  import ram4p_pkg::*;
#(
  parameter int ADDR_W     = ram4p_pkg::ADDR_W,
  parameter int DATA_W     = ram4p_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          req_valid,
  output logic [3:0]          req_ready,
  input  logic [3:0]          req_wr,
  input  logic [4*ADDR_W-1:0] req_addr,
  input  logic [4*DATA_W-1:0] req_wdata,
  output logic [3:0]          rsp_valid,
  output logic [4*DATA_W-1:0] rsp_rdata,
  output logic [3:0]          ram_cs,
  output logic [3:0]          ram_wr,
  output logic [4*ADDR_W-1:0] ram_addr,
  output logic [4*DATA_W-1:0] ram_wdata,
  input  logic [4*DATA_W-1:0] ram_rdata,
  output logic [15:0]         stall_cnt
);

  localparam int EW = 1 + ADDR_W + DATA_W;

  logic                 ready_en;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] issue;
  logic [NUM_PORTS-1:0] blocked;
  logic [NUM_PORTS-1:0] head_wr;
  logic [NUM_PORTS-1:0] rd_q;
  logic [NUM_PORTS-1:0] rsp_pend;
  logic [EW-1:0]        head       [NUM_PORTS];
  logic [ADDR_W-1:0]    head_addr  [NUM_PORTS];
  logic [DATA_W-1:0]    head_wdata [NUM_PORTS];
  logic [1:0]           ptr;
  logic [1:0]           pk;
  logic [1:0]           pj;
  logic                 hit;
  logic [2:0]           n_blocked;
  logic [16:0]          stall_sum;

  assign req_ready = {NUM_PORTS{ready_en}} & ~full;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign push[p] = req_valid[p] & req_ready[p];

    req_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[p]),
      .din   ({req_wr[p], req_addr[p*ADDR_W +: ADDR_W], req_wdata[p*DATA_W +: DATA_W]}),
      .pop   (issue[p]),
      .dout  (head[p]),
      .full  (full[p]),
      .empty (empty[p])
    );

    assign head_wr[p]    = head[p][EW-1];
    assign head_addr[p]  = head[p][DATA_W +: ADDR_W];
    assign head_wdata[p] = head[p][DATA_W-1:0];
  end

  // Walk heads in priority order; a write yields to any earlier same-address write head.
  always_comb begin
    blocked = '0;
    issue   = '0;
    pk      = '0;
    pj      = '0;
    hit     = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      pk  = ptr + 2'(k);
      hit = 1'b0;
      if (!empty[pk] && head_wr[pk]) begin
        for (int j = 0; j < k; j++) begin
          pj = ptr + 2'(j);
          if (!empty[pj] && head_wr[pj] && (head_addr[pj] == head_addr[pk])) begin
            hit = 1'b1;
          end else begin
            hit = hit;
          end
        end
      end else begin
        hit = 1'b0;
      end
      blocked[pk] = hit;
      issue[pk]   = ~empty[pk] & ~hit;
    end
  end

  assign n_blocked = 3'($countones(blocked));
  assign stall_sum = {1'b0, stall_cnt} + {14'd0, n_blocked};
  assign rd_q      = ram_cs & ~ram_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      ptr       <= PORT_A;
      stall_cnt <= 16'd0;
    end else begin
      ready_en  <= 1'b1;
      stall_cnt <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
      // Rotating on any blocked write caps how long one write can be starved.
      if (|blocked) begin
        ptr <= ptr + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cs    <= '0;
      ram_wr    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_cs <= issue;
      ram_wr <= issue & head_wr;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (issue[p]) begin
          ram_addr[p*ADDR_W +: ADDR_W]  <= head_addr[p];
          ram_wdata[p*DATA_W +: DATA_W] <= head_wdata[p];
        end
      end
    end
  end

  // RAM samples one edge after drive; its output is captured one edge after that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pend  <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_pend  <= rd_q;
      rsp_valid <= rsp_pend;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (rsp_pend[p]) begin
          rsp_rdata[p*DATA_W +: DATA_W] <= ram_rdata[p*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule
